sdram2fifo: RTL

- Read-side counterpart of the camera write path.
- Fetches one frame of 16-bit pixels from SDRAM in fixed bursts and pushes them into the display dual-clock FIFO's write port, keeping the FIFO topped up for the VGA reader.
- Runs entirely in the 133 MHz SDRAM domain. Issues read requests to the SDRAM controller and qualifies data with the controller's work_st.

---
 rtl/sdram2fifo.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram2fifo.sv
`default_nettype none
// ============================================================================
// Module   : sdram2fifo
// Purpose  : Reads one frame of 16-bit pixels out of SDRAM in fixed-length
//            bursts and writes them into the display dual-clock FIFO. It only
//            requests a burst when the FIFO has room for a full burst.
//            Everything runs in the 133 MHz SDRAM clock domain.
// Option   : SDRAM2FIFO_UNDERRUN_CNT_EN builds a saturating counter of the
//            cycles where the FIFO is empty in the middle of a frame.
//            Without it, underrun_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sdram2fifo #(
    parameter int                BURST_LEN   = 256,
    parameter int                FIFO_DEPTH  = 2048,
    parameter int                FRAME_WORDS = 307200,
    parameter int                ADDR_W      = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                CLR_CYC     = 4
) (
    input  logic              clk_133M_i,
    input  logic              rst_133i,
    input  logic              frame_start,
    input  logic [10:0]       fifo_wrusedw,
    input  logic [4:0]        work_st,
    input  logic [15:0]       rd_sdram_data,
    input  logic              rd_ack_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [8:0]        rd_len_o,
    output logic [15:0]       fifo_wr_data,
    output logic              fifo_wr_en,
    output logic              clear_rdsdram_fifo,
    output logic              frame_done,
    output logic [15:0]       underrun_cnt
);

    // Controller state code that marks a valid read-data beat
    localparam logic [4:0] W_RDDAT = 5'd6;

    // Width and terminal value of the FIFO-clear cycle counter
    localparam int              CNT_W    = $clog2(CLR_CYC + 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);

    // Sized copies of the frame/burst geometry used in comparisons
    localparam logic [18:0] FRAME_W19 = 19'(FRAME_WORDS);
    localparam logic [18:0] BURST_W19 = 19'(BURST_LEN);
    localparam logic [8:0]  BURST_W9  = 9'(BURST_LEN);
    localparam logic [11:0] ROOM_LIM  = 12'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_WAIT_ROOM = 3'd2,
        S_REQ       = 3'd3,
        S_BURST     = 3'd4,
        S_NEXT      = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [18:0]      words_left;
    logic [8:0]       beat_cnt;
    logic [CNT_W-1:0] clr_cnt;
    logic             start_pend;

    logic             beat_valid;
    logic [8:0]       beat_next;
    logic             room_ok;
    logic [8:0]       first_len;
    logic             enter_clear;

    // A beat only counts while a burst is open; stray W_RDDAT cycles are ignored
    assign beat_valid = (state == S_BURST) && (work_st == W_RDDAT);
    assign beat_next  = beat_cnt + 9'd1;

    // Room for a whole burst means the fill level is at most depth minus burst
    assign room_ok    = ({1'b0, fifo_wrusedw} <= ROOM_LIM);

    // The last burst of a frame is shortened to the words that remain
    assign first_len  = (words_left < BURST_W19) ? words_left[8:0] : BURST_W9;

    // Entering CLEAR, either from another state or by restarting it, re-arms the frame
    assign enter_clear = (state_nxt == S_CLEAR) && ((state != S_CLEAR) || frame_start);

    // State register
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (frame_start) begin
                    state_nxt = S_CLEAR;
                end else if (clr_cnt == CLR_LAST) begin
                    state_nxt = S_WAIT_ROOM;
                end
            end
            S_WAIT_ROOM: begin
                if (frame_start) begin
                    state_nxt = S_CLEAR;
                end else if (words_left == 19'd0) begin
                    state_nxt = S_IDLE;
                end else if (room_ok) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the same cycle as frame_start wins: the burst is already committed
                if (rd_ack_i) begin
                    state_nxt = S_BURST;
                end else if (frame_start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_BURST: begin
                if (beat_valid && (beat_next == rd_len_o)) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (start_pend || frame_start) begin
                    state_nxt = S_CLEAR;
                end else begin
                    state_nxt = S_WAIT_ROOM;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs, burst bookkeeping and frame counters
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            rd_req_o           <= 1'b0;
            rd_addr_o          <= BASE_ADDR;
            rd_len_o           <= 9'd0;
            fifo_wr_data       <= 16'd0;
            fifo_wr_en         <= 1'b0;
            clear_rdsdram_fifo <= 1'b0;
            frame_done         <= 1'b0;
            words_left         <= 19'd0;
            beat_cnt           <= 9'd0;
            clr_cnt            <= '0;
            start_pend         <= 1'b0;
        end else begin
            rd_req_o           <= (state_nxt == S_REQ);
            clear_rdsdram_fifo <= (state_nxt == S_CLEAR);
            fifo_wr_en         <= beat_valid;

            if (beat_valid) begin
                fifo_wr_data <= rd_sdram_data;
                beat_cnt     <= beat_next;
            end

            if (state == S_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end

            if ((state == S_WAIT_ROOM) && (state_nxt == S_REQ)) begin
                rd_len_o <= first_len;
            end

            if ((state == S_WAIT_ROOM) && (state_nxt == S_IDLE)) begin
                frame_done <= 1'b1;
            end

            if ((state == S_REQ) && rd_ack_i) begin
                beat_cnt <= 9'd0;
                if (frame_start) begin
                    start_pend <= 1'b1;
                end
            end

            // A burst cannot be aborted, so a new frame is remembered until it ends
            if (((state == S_BURST) || (state == S_NEXT)) && frame_start) begin
                start_pend <= 1'b1;
            end

            // Address arithmetic wraps silently at the top of SDRAM
            if (state == S_NEXT) begin
                rd_addr_o  <= rd_addr_o + ADDR_W'(rd_len_o);
                words_left <= words_left - {10'd0, rd_len_o};
            end

            // Placed last so a frame restart overrides the NEXT-state advance
            if (enter_clear) begin
                clr_cnt    <= '0;
                rd_addr_o  <= BASE_ADDR;
                words_left <= FRAME_W19;
                frame_done <= 1'b0;
                start_pend <= 1'b0;
            end
        end
    end

`ifdef SDRAM2FIFO_UNDERRUN_CNT_EN
    // Count cycles the display FIFO is empty while the frame still has words to fetch
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            underrun_cnt <= 16'd0;
        end else if (enter_clear) begin
            underrun_cnt <= 16'd0;
        end else if ((fifo_wrusedw == 11'd0) && (words_left != 19'd0) &&
                     (state != S_CLEAR) && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
